// File: rtl/cyclic_correlation_accumulator.sv
// Cyclic correlation accumulator: S = sum_p A_p[a] * B_p[b] over P stored blocks (B pre-conjugated).
// Build option SCF_AVERAGE_EN: output is the accumulator arithmetically shifted right by NB_BLK.
module cyclic_correlation_accumulator #(
  parameter int P       = 32,
  parameter int NP      = 1024,
  parameter int NB_DATA = 16,
  localparam int NB_BLK  = $clog2(P),
  localparam int NB_BIN  = $clog2(NP),
  localparam int NB_PROD = 2 * NB_DATA + 1,
  localparam int NB_ACC  = NB_PROD + NB_BLK
) (
  input  logic                      clock,
  input  logic                      i_reset,
  input  logic                      i_enable,
  input  logic                      i_start,
  input  logic                      i_storage_ready,
  input  logic        [NB_BIN-1:0]  i_bin_a,
  input  logic        [NB_BIN-1:0]  i_bin_b,
  output logic        [NB_BLK-1:0]  o_rd_block,
  output logic        [NB_BIN-1:0]  o_rd_bin_a,
  output logic        [NB_BIN-1:0]  o_rd_bin_b,
  output logic                      o_rd_en,
  input  logic signed [NB_DATA-1:0] i_a_re,
  input  logic signed [NB_DATA-1:0] i_a_im,
  input  logic signed [NB_DATA-1:0] i_b_re,
  input  logic signed [NB_DATA-1:0] i_b_im,
  output logic signed [NB_ACC-1:0]  o_s_re,
  output logic signed [NB_ACC-1:0]  o_s_im,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic                      o_busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0] state;
  logic       rd_active;
  logic       data_vld;
  logic       prod_vld;

  logic signed [2*NB_DATA-1:0] m_rr, m_ii, m_ri, m_ir;
  logic signed [NB_PROD-1:0]   prod_re_next, prod_im_next;
  logic signed [NB_PROD-1:0]   prod_re, prod_im;
  logic signed [NB_ACC-1:0]    acc_re, acc_im;
  logic signed [NB_ACC-1:0]    res_re, res_im;

  always_comb begin
    m_rr = i_a_re * i_b_re;
    m_ii = i_a_im * i_b_im;
    m_ri = i_a_re * i_b_im;
    m_ir = i_a_im * i_b_re;
    prod_re_next = $signed({m_rr[2*NB_DATA-1], m_rr}) - $signed({m_ii[2*NB_DATA-1], m_ii});
    prod_im_next = $signed({m_ri[2*NB_DATA-1], m_ri}) + $signed({m_ir[2*NB_DATA-1], m_ir});
  end

  always_comb begin
`ifdef SCF_AVERAGE_EN
    res_re = acc_re >>> NB_BLK;
    res_im = acc_im >>> NB_BLK;
`else
    res_re = acc_re;
    res_im = acc_im;
`endif
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      state      <= IDLE;
      rd_active  <= 1'b0;
      data_vld   <= 1'b0;
      prod_vld   <= 1'b0;
      o_rd_block <= '0;
      o_rd_bin_a <= '0;
      o_rd_bin_b <= '0;
      prod_re    <= '0;
      prod_im    <= '0;
      acc_re     <= '0;
      acc_im     <= '0;
      o_s_re     <= '0;
      o_s_im     <= '0;
      o_valid    <= 1'b0;
    end else if (i_enable) begin
      // RAM data returns one clock after the strobe, product one clock after that.
      data_vld <= rd_active;
      prod_vld <= data_vld;
      if (data_vld) begin
        prod_re <= prod_re_next;
        prod_im <= prod_im_next;
      end
      if (prod_vld) begin
        acc_re <= acc_re + $signed({{NB_BLK{prod_re[NB_PROD-1]}}, prod_re});
        acc_im <= acc_im + $signed({{NB_BLK{prod_im[NB_PROD-1]}}, prod_im});
      end

      case (state)
        IDLE: begin
          if (i_start && i_storage_ready) begin
            state      <= READ;
            rd_active  <= 1'b1;
            o_rd_block <= '0;
            o_rd_bin_a <= i_bin_a;
            o_rd_bin_b <= i_bin_b;
            acc_re     <= '0;
            acc_im     <= '0;
          end
        end
        READ: begin
          o_rd_block <= o_rd_block + NB_BLK'(1);
          if (o_rd_block == NB_BLK'(P - 2)) state <= DRAIN;
        end
        DRAIN: begin
          // The last address is still presented for one clock after entering DRAIN.
          if (rd_active) begin
            rd_active <= 1'b0;
          end else if (!data_vld && !prod_vld) begin
            o_s_re  <= res_re;
            o_s_im  <= res_im;
            o_valid <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_rd_en = rd_active & i_enable;
  assign o_busy  = (state != IDLE);

endmodule

// File: tb/tb_cyclic_correlation_accumulator.sv
// Randomised self-checking bench for cyclic_correlation_accumulator with a behavioural RAM and
// reference model; honours SCF_AVERAGE_EN when defined.
module tb_cyclic_correlation_accumulator;
  localparam int P       = 4;
  localparam int NP      = 16;
  localparam int NB_DATA = 16;
  localparam int NB_BLK  = $clog2(P);
  localparam int NB_BIN  = $clog2(NP);
  localparam int NB_ACC  = 2 * NB_DATA + 1 + NB_BLK;

  logic clk = 0;
  logic reset = 1, enable = 1, start = 0, storage_ready = 1, ready = 0;
  logic [NB_BIN-1:0] bin_a = '0, bin_b = '0;
  logic [NB_BLK-1:0] rd_block;
  logic [NB_BIN-1:0] rd_bin_a, rd_bin_b;
  logic rd_en, valid, busy;
  logic signed [NB_DATA-1:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
  logic signed [NB_ACC-1:0] s_re, s_im;

  logic signed [NB_DATA-1:0] mem_a_re [P][NP];
  logic signed [NB_DATA-1:0] mem_a_im [P][NP];
  logic signed [NB_DATA-1:0] mem_b_re [P][NP];
  logic signed [NB_DATA-1:0] mem_b_im [P][NP];
  int rd_count [P];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cyclic_correlation_accumulator #(.P(P), .NP(NP), .NB_DATA(NB_DATA)) dut (
    .clock(clk), .i_reset(reset), .i_enable(enable), .i_start(start),
    .i_storage_ready(storage_ready), .i_bin_a(bin_a), .i_bin_b(bin_b),
    .o_rd_block(rd_block), .o_rd_bin_a(rd_bin_a), .o_rd_bin_b(rd_bin_b), .o_rd_en(rd_en),
    .i_a_re(a_re), .i_a_im(a_im), .i_b_re(b_re), .i_b_im(b_im),
    .o_s_re(s_re), .o_s_im(s_im), .o_valid(valid), .i_ready(ready), .o_busy(busy)
  );

  // Dual-port RAM with 1-cycle latency; counts every read per block.
  always @(posedge clk) begin
    if (rd_en) begin
      a_re <= mem_a_re[rd_block][rd_bin_a];
      a_im <= mem_a_im[rd_block][rd_bin_a];
      b_re <= mem_b_re[rd_block][rd_bin_b];
      b_im <= mem_b_im[rd_block][rd_bin_b];
      rd_count[rd_block] = rd_count[rd_block] + 1;
    end
  end

  task automatic fill_const(input int ar, ai, br, bi);
    for (int p = 0; p < P; p++)
      for (int n = 0; n < NP; n++) begin
        mem_a_re[p][n] = NB_DATA'(ar); mem_a_im[p][n] = NB_DATA'(ai);
        mem_b_re[p][n] = NB_DATA'(br); mem_b_im[p][n] = NB_DATA'(bi);
      end
  endtask

  task automatic fill_random();
    for (int p = 0; p < P; p++)
      for (int n = 0; n < NP; n++) begin
        mem_a_re[p][n] = NB_DATA'($urandom); mem_a_im[p][n] = NB_DATA'($urandom);
        mem_b_re[p][n] = NB_DATA'($urandom); mem_b_im[p][n] = NB_DATA'($urandom);
      end
  endtask

  // Reference: complex sum over blocks of A[a]*B[b], optionally divided by P (floor).
  task automatic model(input int a, b, output longint re, output longint im);
    longint ar, ai, br, bi;
    re = 0; im = 0;
    for (int p = 0; p < P; p++) begin
      ar = longint'(mem_a_re[p][a]); ai = longint'(mem_a_im[p][a]);
      br = longint'(mem_b_re[p][b]); bi = longint'(mem_b_im[p][b]);
      re += ar * br - ai * bi;
      im += ar * bi + ai * br;
    end
`ifdef SCF_AVERAGE_EN
    re = re >>> NB_BLK;
    im = im >>> NB_BLK;
`endif
  endtask

  // Runs one computation; ok=0 on timeout or if the handshake does not return to idle.
  task automatic run(input int a, b, stall_at, stall_len, ready_wait, extra_start,
                     output longint re, output longint im, output int lat,
                     output bit ok, output bit stable, output bit once);
    int cnt, stall_used, guard;
    bit en_now;
    for (int p = 0; p < P; p++) rd_count[p] = 0;
    ok = 1; stable = 1; once = 1;
    @(negedge clk);
    bin_a = a[NB_BIN-1:0]; bin_b = b[NB_BIN-1:0];
    start = 1; ready = 0; enable = 1;
    @(negedge clk);
    start = 0; cnt = 0; stall_used = 0; guard = 0;
    while (!valid) begin
      if (guard > 200) begin ok = 0; break; end
      en_now = 1;
      if (cnt == stall_at && stall_used < stall_len) begin en_now = 0; stall_used++; end
      start = (cnt == extra_start) && en_now;
      if (start) storage_ready = 0;
      enable = en_now;
      @(negedge clk);
      guard++;
      if (en_now) cnt++;
    end
    enable = 1; start = 0;
    lat = cnt;
    re = longint'(s_re); im = longint'(s_im);
    for (int i = 0; i < ready_wait; i++) begin
      @(negedge clk);
      if (valid !== 1'b1 || longint'(s_re) != re || longint'(s_im) != im) stable = 0;
    end
    ready = 1;
    @(negedge clk);
    ready = 0; storage_ready = 1;
    if (valid !== 1'b0 || busy !== 1'b0) ok = 0;
    for (int p = 0; p < P; p++) if (rd_count[p] != 1) once = 0;
  endtask

  task automatic test_reset();
    bit seen;
    reset = 1;
    @(negedge clk); @(negedge clk);
    checks++;
    if (busy !== 0 || valid !== 0 || rd_en !== 0 || s_re !== '0 || s_im !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b valid=%b rd_en=%b s=(%0d,%0d) need all 0",
               busy, valid, rd_en, s_re, s_im);
    end
    reset = 0;
    fill_const(1, 0, 1, 0);
    @(negedge clk);
    start = 1; bin_a = 1; bin_b = 2;
    @(negedge clk); start = 0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    checks++;
    if (busy !== 0 || valid !== 0 || rd_en !== 0) begin
      errors++;
      $display("FAIL reset_midrun: busy=%b valid=%b rd_en=%b need 0 0 0", busy, valid, rd_en);
    end
    seen = 0;
    for (int i = 0; i < P + 8; i++) begin
      @(negedge clk);
      if (valid !== 0 || rd_en !== 0) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_no_result: activity seen=%b need 0", seen);
    end
  endtask

  task automatic check_run(input string name, input int a, b, stall_at, stall_len,
                           ready_wait, extra_start);
    longint re, im, ere, eim;
    int lat;
    bit ok, stable, once;
    model(a, b, ere, eim);
    run(a, b, stall_at, stall_len, ready_wait, extra_start, re, im, lat, ok, stable, once);
    checks++;
    if (re != ere || im != eim) begin
      errors++;
      $display("FAIL %s_result: got (%0d,%0d) need (%0d,%0d)", name, re, im, ere, eim);
    end
    checks++;
    if (lat != P + 3 || !ok) begin
      errors++;
      $display("FAIL %s_latency: got %0d ok=%b need %0d ok=1", name, lat, ok, P + 3);
    end
    checks++;
    if (!stable || !once) begin
      errors++;
      $display("FAIL %s_hold_reads: stable=%b single_reads=%b need 1 1", name, stable, once);
    end
  endtask

  task automatic test_impulse();
    longint exp_re;
    fill_const(1, 0, 1, 0);
    check_run("impulse", 3, 5, -1, 0, 0, -1);
    exp_re = P;
`ifdef SCF_AVERAGE_EN
    exp_re = 1;
`endif
    checks++;
    if (longint'(s_re) != exp_re || s_im !== '0) begin
      errors++;
      $display("FAIL impulse_value: got (%0d,%0d) need (%0d,0)", s_re, s_im, exp_re);
    end
  endtask

  task automatic test_complex();
    fill_const(3, 4, 3, -4);
    check_run("complex_same_bin", 7, 7, -1, 0, 0, -1);
  endtask

  task automatic test_extremes();
    fill_const(-32768, -32768, -32768, -32768);
    check_run("extremes", 0, NP - 1, -1, 0, 0, -1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      fill_random();
      check_run("random", int'($urandom_range(0, NP - 1)), int'($urandom_range(0, NP - 1)),
                -1, 0, int'($urandom_range(0, 3)), -1);
    end
  endtask

  task automatic test_stall_backpressure();
    fill_random();
    check_run("stall", 2, 9, 2, 5, 10, -1);
    fill_random();
    check_run("stall_drain", 4, 4, P + 1, 3, 2, -1);
  endtask

  task automatic test_start_gating();
    bit seen;
    fill_random();
    storage_ready = 0;
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (rd_en !== 0 || busy !== 0) seen = 1;
      @(negedge clk);
    end
    storage_ready = 1;
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL gate_not_ready: activity seen=%b need 0", seen);
    end
    check_run("gate_busy", 6, 11, -1, 0, 0, 2);
  endtask

  task automatic test_back_to_back();
    fill_random();
    check_run("b2b_first", 1, 2, -1, 0, 0, -1);
    check_run("b2b_second", 2, 1, -1, 0, 1, -1);
  endtask

  initial begin
    fill_const(0, 0, 0, 0);
    for (int p = 0; p < P; p++) rd_count[p] = 0;
    test_reset();
    test_impulse();
    test_complex();
    test_extremes();
    test_random();
    test_stall_backpressure();
    test_start_gating();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
